// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, ALU flag bit positions,
// set-select encodings and the EX/MEM boundary state encoding.
package pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 3;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_COUT = 2;
  localparam int FLAG_OFL  = 3;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_SLT = 2'b01,
    SEL_SLE = 2'b10,
    SEL_SCO = 2'b11
  } setSelect_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } exMemState_t;

endpackage

// File: rtl/ex_mem_entry.sv
// One EX/MEM bundle register. rst zeroes data and valid; clrEn only drops
// valid so the data fields keep their last value across bubbles.
module ex_mem_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         loadEn,
  input  logic         clrEn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (loadEn) begin
      q     <= d;
      valid <= 1'b1;
    end else if (clrEn) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary register. With EXMEM_SKID_EN defined it is a
// two-entry skid buffer with a registered in_ready; otherwise a single entry
// whose in_ready is combinational from out_ready.
module ex_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [3:0]        in_alu_flags,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic [2:0]        in_set_select,
  input  logic              in_reg_write,
  input  logic              in_dmem_write,
  input  logic              in_dmem_en,
  input  logic              in_dmem_dump,
  input  logic              in_mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [3:0]        out_alu_flags,
  output logic [REG_W-1:0]  out_write_reg,
  output logic [2:0]        out_set_select,
  output logic              out_reg_write,
  output logic              out_dmem_write,
  output logic              out_dmem_en,
  output logic              out_dmem_dump,
  output logic              out_mem_to_reg,
  output logic [1:0]        dbgState,
  output logic [1:0]        dbgOccupancy
);

  // Handshake: a transfer happens on a port in any cycle where its valid and
  // ready are both high; valid never waits on ready, and an offered bundle
  // is held stable by its producer until it transfers (or a flush kills it).

  localparam int BW = 2*DATA_W + REG_W + 12;

  exMemState_t stateQ, stateNext;
  logic [BW-1:0] inBundle, mainD, mainQ;
  logic mainLoad, mainClr, mainValid, skidValid;
  logic inXfer, outXfer;
  logic regWriteQ, dmemWriteQ, dmemEnQ, dmemDumpQ;

  assign inBundle = {in_alu_result, in_store_data, in_alu_flags, in_write_reg,
                     in_set_select, in_reg_write, in_dmem_write, in_dmem_en,
                     in_dmem_dump, in_mem_to_reg};

  assign out_valid = (stateQ != ST_EMPTY);
  assign outXfer   = out_valid & out_ready;
  assign inXfer    = in_valid & in_ready;

`ifdef EXMEM_SKID_EN
  logic [BW-1:0] skidQ;
  logic skidLoad, skidClr, inReadyQ;

  assign in_ready = inReadyQ;

  ex_mem_entry #(.W(BW)) uSkid (
    .clk    (clk),
    .rst    (rst),
    .loadEn (skidLoad),
    .clrEn  (skidClr),
    .d      (inBundle),
    .q      (skidQ),
    .valid  (skidValid)
  );
`else
  assign in_ready  = ~out_valid | out_ready;
  assign skidValid = 1'b0;
  assign mainD     = inBundle;
`endif

  ex_mem_entry #(.W(BW)) uMain (
    .clk    (clk),
    .rst    (rst),
    .loadEn (mainLoad),
    .clrEn  (mainClr),
    .d      (mainD),
    .q      (mainQ),
    .valid  (mainValid)
  );

  always_comb begin
    stateNext = stateQ;
    mainLoad  = 1'b0;
    mainClr   = 1'b0;
`ifdef EXMEM_SKID_EN
    skidLoad  = 1'b0;
    skidClr   = 1'b0;
    mainD     = inBundle;
`endif
    if (flush) begin
      // A bundle offered alongside the flush is dropped by not loading it.
      stateNext = ST_EMPTY;
      mainClr   = 1'b1;
`ifdef EXMEM_SKID_EN
      skidClr   = 1'b1;
`endif
    end else begin
      case (stateQ)
        ST_EMPTY: begin
          if (inXfer) begin
            stateNext = ST_ONE;
            mainLoad  = 1'b1;
          end
        end
        ST_ONE: begin
          if (inXfer && outXfer) begin
            mainLoad = 1'b1;
          end else if (outXfer) begin
            stateNext = ST_EMPTY;
            mainClr   = 1'b1;
`ifdef EXMEM_SKID_EN
          end else if (inXfer) begin
            stateNext = ST_TWO;
            skidLoad  = 1'b1;
`endif
          end
        end
`ifdef EXMEM_SKID_EN
        ST_TWO: begin
          if (outXfer) begin
            stateNext = ST_ONE;
            mainLoad  = 1'b1;
            mainD     = skidQ;
            skidClr   = 1'b1;
          end
        end
`endif
        default: stateNext = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= ST_EMPTY;
`ifdef EXMEM_SKID_EN
      inReadyQ <= 1'b1;
`endif
    end else begin
      stateQ   <= stateNext;
`ifdef EXMEM_SKID_EN
      inReadyQ <= (stateNext != ST_TWO);
`endif
    end
  end

  assign {out_alu_result, out_store_data, out_alu_flags, out_write_reg,
          out_set_select, regWriteQ, dmemWriteQ, dmemEnQ, dmemDumpQ,
          out_mem_to_reg} = mainQ;

  // Side-effecting strobes must never fire on a bubble.
  assign out_reg_write  = regWriteQ  & out_valid;
  assign out_dmem_write = dmemWriteQ & out_valid;
  assign out_dmem_en    = dmemEnQ    & out_valid;
  assign out_dmem_dump  = dmemDumpQ  & out_valid;

  assign dbgState     = stateQ;
  assign dbgOccupancy = {skidValid, mainValid};

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg; expectations follow the build's
// EXMEM_SKID_EN setting.
module tb_ex_mem_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_alu_result = '0;
  logic [15:0] in_store_data = '0;
  logic [3:0]  in_alu_flags = '0;
  logic [2:0]  in_write_reg = '0;
  logic [2:0]  in_set_select = '0;
  logic        in_reg_write = 1'b0;
  logic        in_dmem_write = 1'b0;
  logic        in_dmem_en = 1'b0;
  logic        in_dmem_dump = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_alu_result;
  logic [15:0] out_store_data;
  logic [3:0]  out_alu_flags;
  logic [2:0]  out_write_reg;
  logic [2:0]  out_set_select;
  logic        out_reg_write;
  logic        out_dmem_write;
  logic        out_dmem_en;
  logic        out_dmem_dump;
  logic        out_mem_to_reg;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_occupancy;

  int n_checks = 0;
  int n_fail = 0;

  ex_mem_skid_reg #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_alu_flags(in_alu_flags), .in_write_reg(in_write_reg),
    .in_set_select(in_set_select), .in_reg_write(in_reg_write),
    .in_dmem_write(in_dmem_write), .in_dmem_en(in_dmem_en),
    .in_dmem_dump(in_dmem_dump), .in_mem_to_reg(in_mem_to_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_alu_flags(out_alu_flags), .out_write_reg(out_write_reg),
    .out_set_select(out_set_select), .out_reg_write(out_reg_write),
    .out_dmem_write(out_dmem_write), .out_dmem_en(out_dmem_en),
    .out_dmem_dump(out_dmem_dump), .out_mem_to_reg(out_mem_to_reg),
    .dbgState(dbg_state), .dbgOccupancy(dbg_occupancy)
  );

  // clock
  always #5 clk = ~clk;

  // driver: ctrl = {reg_write, dmem_write, dmem_en, dmem_dump, mem_to_reg}
  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [2:0] wr, input logic [4:0] ctrl, input logic ordy);
    in_valid      = v;
    in_alu_result = alu;
    in_store_data = sd;
    in_alu_flags  = alu[7:4];
    in_write_reg  = wr;
    in_set_select = {1'b1, alu[5:4]};
    {in_reg_write, in_dmem_write, in_dmem_en, in_dmem_dump, in_mem_to_reg} = ctrl;
    out_ready     = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'h7777, 16'h7777, 3'd7, 5'b11111, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 3'd0, 5'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if ({out_alu_result, out_store_data, out_alu_flags, out_write_reg, out_set_select,
         out_reg_write, out_dmem_write, out_dmem_en, out_dmem_dump, out_mem_to_reg} !== 50'd0) begin
      n_fail++; $display("FAIL reset fields: got alu=%h sd=%h fl=%h wr=%h sel=%h ctrl=%b expected all 0",
        out_alu_result, out_store_data, out_alu_flags, out_write_reg, out_set_select,
        {out_reg_write, out_dmem_write, out_dmem_en, out_dmem_dump, out_mem_to_reg});
    end
    n_checks++;
    if (dbg_state !== 2'(ST_EMPTY)) begin
      n_fail++; $display("FAIL reset state: got %0d expected %0d", dbg_state, ST_EMPTY);
    end
    next_cycle();
  endtask

  task automatic test_streaming();
    logic [15:0] exp_alu;
    for (int i = 0; i <= 4; i++) begin
      drive(i < 4, 16'(16 * (i + 1)), 16'h0, 3'd1, 5'b10000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream c%0d in_ready: got %b expected 1", i, in_ready);
      end
      if (i > 0) begin
        exp_alu = 16'(16 * i);
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_result !== exp_alu) begin
          n_fail++; $display("FAIL stream c%0d out: got valid=%b alu=%h expected valid=1 alu=%h",
                             i, out_valid, out_alu_result, exp_alu);
        end
        n_checks++;
        if (out_alu_flags !== exp_alu[7:4] || out_set_select !== {1'b1, exp_alu[5:4]}) begin
          n_fail++; $display("FAIL stream c%0d flags/sel: got %h/%h expected %h/%h",
                             i, out_alu_flags, out_set_select, exp_alu[7:4], {1'b1, exp_alu[5:4]});
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream drain out_valid: got %b expected 0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_stall_fill();
`ifdef EXMEM_SKID_EN
    logic        v_v   [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [15:0] alu_v [7] = '{16'h1111, 16'h2222, 16'h3333, 16'h3333, 16'h3333, 16'h0, 16'h0};
    logic        ord_v [7] = '{0, 0, 0, 1, 1, 1, 1};
    logic        ir_e  [7] = '{1, 1, 0, 0, 1, 1, 1};
    logic        ov_e  [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [15:0] alu_e [7] = '{16'h0, 16'h1111, 16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    logic [1:0]  st_e  [7] = '{ST_EMPTY, ST_ONE, ST_TWO, ST_TWO, ST_ONE, ST_ONE, ST_EMPTY};
`else
    logic        v_v   [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [15:0] alu_v [7] = '{16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h3333, 16'h0, 16'h0};
    logic        ord_v [7] = '{0, 0, 0, 1, 1, 1, 1};
    logic        ir_e  [7] = '{1, 0, 0, 1, 1, 1, 1};
    logic        ov_e  [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [15:0] alu_e [7] = '{16'h0, 16'h1111, 16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    logic [1:0]  st_e  [7] = '{ST_EMPTY, ST_ONE, ST_ONE, ST_ONE, ST_ONE, ST_ONE, ST_EMPTY};
`endif
    for (int c = 0; c < 7; c++) begin
      drive(v_v[c], alu_v[c], 16'h0, 3'd2, 5'b00001, ord_v[c]);
      @(negedge clk);
      n_checks++;
      if (in_ready !== ir_e[c]) begin
        n_fail++; $display("FAIL stall c%0d in_ready: got %b expected %b", c, in_ready, ir_e[c]);
      end
      n_checks++;
      if (out_valid !== ov_e[c]) begin
        n_fail++; $display("FAIL stall c%0d out_valid: got %b expected %b", c, out_valid, ov_e[c]);
      end
      if (ov_e[c]) begin
        n_checks++;
        if (out_alu_result !== alu_e[c]) begin
          n_fail++; $display("FAIL stall c%0d out_alu_result: got %h expected %h", c, out_alu_result, alu_e[c]);
        end
      end
      n_checks++;
      if (dbg_state !== st_e[c]) begin
        n_fail++; $display("FAIL stall c%0d state: got %0d expected %0d", c, dbg_state, st_e[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h5555, 16'h0, 3'd3, 5'b00100, 1'b0);
    next_cycle();
`ifdef EXMEM_SKID_EN
    drive(1'b1, 16'h6666, 16'h0, 3'd3, 5'b00100, 1'b0);
    next_cycle();
`endif
    flush = 1'b1;
    drive(1'b1, 16'h4444, 16'h0, 3'd4, 5'b00100, 1'b0);
    @(negedge clk);
    n_checks++;
`ifdef EXMEM_SKID_EN
    if (dbg_state !== 2'(ST_TWO)) begin
      n_fail++; $display("FAIL flush pre-state: got %0d expected %0d", dbg_state, ST_TWO);
    end
`else
    if (dbg_state !== 2'(ST_ONE)) begin
      n_fail++; $display("FAIL flush pre-state: got %0d expected %0d", dbg_state, ST_ONE);
    end
`endif
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 3'd0, 5'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_dmem_en !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL flush c%0d: got valid=%b dmem_en=%b in_ready=%b expected 0/0/1",
                           c, out_valid, out_dmem_en, in_ready);
      end
      n_checks++;
      if (out_alu_result !== 16'h5555) begin
        n_fail++; $display("FAIL flush c%0d held data: got %h expected 5555", c, out_alu_result);
      end
      next_cycle();
    end
  endtask

  task automatic test_bubble();
    drive(1'b1, 16'h0100, 16'hBEEF, 3'd6, 5'b11100, 1'b1);
    next_cycle();
    drive(1'b0, 16'h0, 16'h0, 3'd0, 5'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_reg_write, out_dmem_write, out_dmem_en} !== 4'b1111 || out_store_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL bubble store: got v/rw/dw/de=%b sd=%h expected 1111 BEEF",
                         {out_valid, out_reg_write, out_dmem_write, out_dmem_en}, out_store_data);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_reg_write, out_dmem_write, out_dmem_en, out_dmem_dump} !== 5'b0) begin
      n_fail++; $display("FAIL bubble strobes: got %b expected 00000",
                         {out_valid, out_reg_write, out_dmem_write, out_dmem_en, out_dmem_dump});
    end
    n_checks++;
    if (out_store_data !== 16'hBEEF || out_write_reg !== 3'd6) begin
      n_fail++; $display("FAIL bubble data: got sd=%h wr=%0d expected BEEF 6", out_store_data, out_write_reg);
    end
    next_cycle();
  endtask

  task automatic test_halt();
    drive(1'b1, 16'h0200, 16'h0, 3'b101, 5'b00011, 1'b1);
    next_cycle();
    drive(1'b0, 16'h0, 16'h0, 3'd0, 5'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_dmem_dump, out_mem_to_reg} !== 3'b111 || out_write_reg !== 3'b101
        || out_alu_result !== 16'h0200) begin
      n_fail++; $display("FAIL halt pass: got v/dump/m2r=%b wr=%b alu=%h expected 111 101 0200",
                         {out_valid, out_dmem_dump, out_mem_to_reg}, out_write_reg, out_alu_result);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (out_dmem_dump !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt bubble: got dump=%b valid=%b expected 0 0", out_dmem_dump, out_valid);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_bubble();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
